// File: rtl/gpr_pkg.sv
// Shared types and sizing for the GPR write-back path.
// The regfile width and depth are defined here once.
package gpr_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = $clog2(NREGS);

    typedef logic [AW-1:0]   gpr_addr_t;
    typedef logic [XLEN-1:0] gpr_data_t;

    typedef struct packed {
        gpr_addr_t addr;
        gpr_data_t data;
    } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
// It returns the first asserted request, searching from ptr and wrapping around.
module rr_arbiter #(
    parameter int N  = 3,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    logic found;
    int   idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!found && req[idx]) begin
                found        = 1'b1;
                grant[idx]   = 1'b1;
                grant_idx    = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/gpr_wb_arbiter.sv
// Round-robin share of the single GPR write port between the write-back sources.
// It registers the winning write, drops writes to x0, and keeps the RAW busy scoreboard.
module gpr_wb_arbiter
    import gpr_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int XLEN    = gpr_pkg::XLEN,
    parameter int NREGS   = gpr_pkg::NREGS,
    localparam int AW     = $clog2(NREGS),
    localparam int PW     = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*AW-1:0]     req_addr,
    input  logic [NUM_REQ*XLEN-1:0]   req_data,
    output logic                      rf_we,
    output logic [AW-1:0]             rf_waddr,
    output logic [XLEN-1:0]           rf_wdata,
    input  logic                      sb_set,
    input  logic [AW-1:0]             sb_set_addr,
    input  logic [AW-1:0]             sb_rs1_addr,
    input  logic [AW-1:0]             sb_rs2_addr,
    output logic                      sb_rs1_busy,
    output logic                      sb_rs2_busy
);

    logic [PW-1:0]      rr_ptr;
    logic [NUM_REQ-1:0] grant;
    logic [PW-1:0]      grant_idx;
    logic               xfer;
    wb_req_t            sel;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Ready is killed during reset so nothing is consumed that the reset would then lose.
    assign req_ready = rst_n ? grant : '0;
    assign xfer      = |req_ready;

    always_comb begin
        sel.addr = req_addr[int'(grant_idx)*AW +: AW];
        sel.data = req_data[int'(grant_idx)*XLEN +: XLEN];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr   <= '0;
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            rf_we <= 1'b0;
            if (xfer) begin
                rr_ptr <= (int'(grant_idx) == NUM_REQ-1) ? '0 : grant_idx + PW'(1);
                if (sel.addr != '0) begin
                    rf_we    <= 1'b1;
                    rf_waddr <= sel.addr;
                    rf_wdata <= sel.data;
                end
            end
        end
    end

    // x0 has no busy flop; it is pinned to 0 in the read vector.
    logic [NREGS-1:1] busy, busy_nxt;
    logic [NREGS-1:0] busy_vec;

    always_comb begin
        busy_nxt = busy;
        if (rf_we && rf_waddr != '0) busy_nxt[rf_waddr] = 1'b0;
        // The set is applied after the clear, so a same-edge set wins.
        if (sb_set && sb_set_addr != '0) busy_nxt[sb_set_addr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) busy <= '0;
        else        busy <= busy_nxt;
    end

    assign busy_vec    = {busy, 1'b0};
    assign sb_rs1_busy = busy_vec[sb_rs1_addr];
    assign sb_rs2_busy = busy_vec[sb_rs2_addr];

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Scoreboard bench for gpr_wb_arbiter.
// Expected writes are queued at the accept cycle and popped when rf_we appears.
module tb_gpr_wb_arbiter;

    localparam int N     = 3;
    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [N-1:0]          req_valid, req_ready;
    logic [N*AW-1:0]       req_addr;
    logic [N*XLEN-1:0]     req_data;
    logic                  rf_we;
    logic [AW-1:0]         rf_waddr;
    logic [XLEN-1:0]       rf_wdata;
    logic                  sb_set;
    logic [AW-1:0]         sb_set_addr, sb_rs1_addr, sb_rs2_addr;
    logic                  sb_rs1_busy, sb_rs2_busy;

    logic [AW-1:0]   a_in [N];
    logic [XLEN-1:0] d_in [N];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign req_addr[g*AW +: AW]     = a_in[g];
        assign req_data[g*XLEN +: XLEN] = d_in[g];
    end

    gpr_wb_arbiter #(.NUM_REQ(N), .XLEN(XLEN), .NREGS(NREGS)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .sb_set      (sb_set),
        .sb_set_addr (sb_set_addr),
        .sb_rs1_addr (sb_rs1_addr),
        .sb_rs2_addr (sb_rs2_addr),
        .sb_rs1_busy (sb_rs1_busy),
        .sb_rs2_busy (sb_rs2_busy)
    );

    typedef struct {
        logic [AW-1:0]   a;
        logic [XLEN-1:0] d;
    } wr_t;

    wr_t             exp_q[$];
    int              m_ptr   = 0;
    logic            m_we    = 1'b0;
    logic [AW-1:0]   m_waddr = '0;
    logic [XLEN-1:0] m_wdata = '0;
    logic [NREGS-1:0] m_busy = '0;
    int              n_tests = 0;
    int              n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Check one cycle at the negedge, then advance the model across the next posedge.
    task automatic tick();
        int   g;
        int   idx;
        wr_t  w;
        logic [N-1:0] eg;
        @(negedge clk);
        chk("rf_we", {63'd0, rf_we}, {63'd0, m_we});
        if (rf_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {63'd0, rf_we}, 64'd0);
            end else begin
                w = exp_q.pop_front();
                chk("rf_waddr", 64'(rf_waddr), 64'(w.a));
                chk("rf_wdata", 64'(rf_wdata), 64'(w.d));
            end
        end else begin
            chk("hold_waddr", 64'(rf_waddr), 64'(m_waddr));
            chk("hold_wdata", 64'(rf_wdata), 64'(m_wdata));
        end
        g = -1;
        if (rst_n) begin
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (g < 0 && req_valid[idx]) g = idx;
            end
        end
        eg = '0;
        if (g >= 0) eg[g] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(eg));
        chk("rs1_busy", {63'd0, sb_rs1_busy}, {63'd0, m_busy[sb_rs1_addr]});
        chk("rs2_busy", {63'd0, sb_rs2_busy}, {63'd0, m_busy[sb_rs2_addr]});
        if (!rst_n) begin
            m_ptr = 0; m_we = 1'b0; m_waddr = '0; m_wdata = '0; m_busy = '0;
            exp_q.delete();
        end else begin
            if (m_we) m_busy[m_waddr] = 1'b0;
            if (sb_set && sb_set_addr != '0) m_busy[sb_set_addr] = 1'b1;
            m_we = 1'b0;
            if (g >= 0) begin
                m_ptr = (g + 1) % N;
                if (a_in[g] != '0) begin
                    m_we = 1'b1; m_waddr = a_in[g]; m_wdata = d_in[g];
                    exp_q.push_back('{a_in[g], d_in[g]});
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_valid = '0;
        sb_set    = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 3'b111; sb_set = 1'b0;
        sb_set_addr = '0; sb_rs1_addr = 5'd7; sb_rs2_addr = 5'd9;
        for (int i = 0; i < N; i++) begin
            a_in[i] = AW'(i + 1); d_in[i] = 32'hA000_0000 + i;
        end
        @(posedge clk);
        #1;
        tick(); tick();

        // All three valid straight out of reset: grants 0,1,2,0
        rst_n = 1'b1;
        repeat (4) tick();
        idle(); tick(); tick();

        // Lone requester 1
        req_valid = 3'b010; a_in[1] = 5'd5; d_in[1] = 32'hDEADBEEF;
        tick();
        idle(); tick(); tick();

        // Write to x0 is consumed without a regfile write
        req_valid = 3'b001; a_in[0] = 5'd0; d_in[0] = 32'h1234;
        tick();
        idle(); tick(); tick();

        // Scoreboard set / commit-clear / same-edge set wins
        sb_rs1_addr = 5'd7;
        sb_set = 1'b1; sb_set_addr = 5'd7; tick();
        sb_set = 1'b0; tick();
        req_valid = 3'b100; a_in[2] = 5'd7; d_in[2] = 32'h7777_0007; tick();
        idle(); tick();
        tick();
        sb_set = 1'b1; sb_set_addr = 5'd7; tick();
        sb_set = 1'b0;
        req_valid = 3'b100; tick();
        idle(); sb_set = 1'b1; sb_set_addr = 5'd7; tick();
        sb_set = 1'b0; tick(); tick();

        // Reset discards a write already on the port and clears state
        sb_set = 1'b1; sb_set_addr = 5'd9; sb_rs2_addr = 5'd9; tick();
        sb_set = 1'b0;
        req_valid = 3'b010; a_in[1] = 5'd9; d_in[1] = 32'h0BAD_F00D; tick();
        req_valid = '0; rst_n = 1'b0; tick();
        rst_n = 1'b1; req_valid = 3'b111; sb_rs1_addr = 5'd9; tick();
        idle(); tick(); tick();

        // Random traffic, with an occasional reset
        for (int c = 0; c < 200; c++) begin
            rst_n     = ($urandom_range(0, 40) != 0);
            req_valid = N'($urandom);
            for (int i = 0; i < N; i++) begin
                a_in[i] = ($urandom_range(0, 5) == 0) ? '0 : AW'($urandom);
                d_in[i] = $urandom;
            end
            sb_set      = $urandom_range(0, 1) == 1;
            sb_set_addr = AW'($urandom);
            sb_rs1_addr = AW'($urandom);
            sb_rs2_addr = AW'($urandom);
            tick();
        end
        rst_n = 1'b1; idle(); tick(); tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
